// File: rtl/axis_decimate_avg.sv
// Decimating boxcar averager/summer for one AXI-Stream channel.
// Produces one result per 2^K input samples and holds it in a tready-handshaked output register.
module axis_decimate_avg #(
    parameter int SAXIS_TDATA_WIDTH     = 32,
    parameter int MAXIS_TDATA_WIDTH     = 32,
    parameter int ACC_WIDTH             = 48,
    parameter int configuration_address = 2100
) (
    input  logic                          a_clk,
    input  logic                          a_rst,
    input  logic [31:0]                   config_addr,
    input  logic [511:0]                  config_data,
    input  logic [SAXIS_TDATA_WIDTH-1:0]  S_AXIS_tdata,
    input  logic                          S_AXIS_tvalid,
    output logic [MAXIS_TDATA_WIDTH-1:0]  M_AXIS_tdata,
    output logic                          M_AXIS_tvalid,
    input  logic                          M_AXIS_tready,
    output logic [31:0]                   block_count,
    output logic [15:0]                   overrun_count,
    output logic                          busy
);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t                               state_q;
    logic [4:0]                           k_q;
    logic                                 mode_q;
    logic signed [ACC_WIDTH-1:0]          acc_q;
    logic [16:0]                          cnt_q;
    logic [MAXIS_TDATA_WIDTH-1:0]         tdata_q;
    logic                                 tvalid_q;
    logic [31:0]                          block_count_q;
    logic [15:0]                          overrun_q;

    logic                                 cfg_hit;
    logic [4:0]                           cfg_k;
    logic signed [SAXIS_TDATA_WIDTH-1:0]  sample;
    logic signed [ACC_WIDTH-1:0]          acc_d;
    logic [16:0]                          cnt_d;
    logic [16:0]                          block_len;
    logic                                 take;
    logic                                 complete;
    logic [MAXIS_TDATA_WIDTH-1:0]         result_d;
    logic                                 unused_cfg;

    function automatic logic [MAXIS_TDATA_WIDTH-1:0] mean_fn(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic [4:0]                  k
    );
        logic signed [ACC_WIDTH-1:0] s;
        s = a >>> k;
        return s[MAXIS_TDATA_WIDTH-1:0];
    endfunction

    // In range when every bit above the output sign bit matches it.
    function automatic logic [MAXIS_TDATA_WIDTH-1:0] sat_fn(
        input logic signed [ACC_WIDTH-1:0] a
    );
        if ((&a[ACC_WIDTH-1:MAXIS_TDATA_WIDTH-1]) || ~(|a[ACC_WIDTH-1:MAXIS_TDATA_WIDTH-1]))
            return a[MAXIS_TDATA_WIDTH-1:0];
        else if (a[ACC_WIDTH-1])
            return {1'b1, {(MAXIS_TDATA_WIDTH-1){1'b0}}};
        else
            return {1'b0, {(MAXIS_TDATA_WIDTH-1){1'b1}}};
    endfunction

    assign unused_cfg = ^{config_data[511:35], config_data[31:5]};

    assign cfg_hit   = (config_addr == 32'(configuration_address));
    assign cfg_k     = (config_data[4:0] > 5'd16) ? 5'd16 : config_data[4:0];
    assign sample    = S_AXIS_tdata;
    assign acc_d     = acc_q + ACC_WIDTH'(sample);
    assign cnt_d     = cnt_q + 17'd1;
    assign block_len = 17'd1 << k_q;
    assign take      = (state_q == ACC) && S_AXIS_tvalid && !cfg_hit;
    assign complete  = take && (cnt_d == block_len);
    assign result_d  = mode_q ? sat_fn(acc_d) : mean_fn(acc_d, k_q);

    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            state_q       <= IDLE;
            k_q           <= '0;
            mode_q        <= 1'b0;
            acc_q         <= '0;
            cnt_q         <= '0;
            tdata_q       <= '0;
            tvalid_q      <= 1'b0;
            block_count_q <= '0;
            overrun_q     <= '0;
        end else begin
            // A fresh result always loads; it counts as an overrun only if it displaces an unaccepted one.
            if (complete) begin
                tdata_q  <= result_d;
                tvalid_q <= 1'b1;
                if (tvalid_q && !M_AXIS_tready && (overrun_q != 16'hFFFF))
                    overrun_q <= overrun_q + 16'd1;
            end else if (M_AXIS_tready) begin
                tvalid_q <= 1'b0;
            end

            if (cfg_hit) begin
                state_q <= config_data[32] ? ACC : IDLE;
                k_q     <= cfg_k;
                mode_q  <= config_data[33];
                acc_q   <= '0;
                cnt_q   <= '0;
                if (config_data[34]) begin
                    block_count_q <= '0;
                    overrun_q     <= '0;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        acc_q <= '0;
                        cnt_q <= '0;
                    end
                    ACC: begin
                        if (complete) begin
                            acc_q         <= '0;
                            cnt_q         <= '0;
                            block_count_q <= block_count_q + 32'd1;
                        end else if (take) begin
                            acc_q <= acc_d;
                            cnt_q <= cnt_d;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign M_AXIS_tdata  = tdata_q;
    assign M_AXIS_tvalid = tvalid_q;
    assign block_count   = block_count_q;
    assign overrun_count = overrun_q;
    assign busy          = (state_q == ACC) && (cnt_q != '0);

endmodule

// File: doc/axis_decimate_avg.md
Name: axis_decimate_avg

Overview:
- Consumes one output stream of the 16->6 AXIS channel selector (e.g. M_AXIS_1) and produces a decimated boxcar mean, or saturated sum, over 2^K samples.
- Sits between the selector and the stream recorder/DMA packer.
- Programmed over the shared config_addr/config_data bus.
- Holds one result in an output register with tready handshake and counts overruns.

Parameters:
- SAXIS_TDATA_WIDTH, 32, signed input sample width.
- MAXIS_TDATA_WIDTH, 32, output width; must equal SAXIS_TDATA_WIDTH.
- ACC_WIDTH, 48, signed accumulator width; must be at least SAXIS_TDATA_WIDTH+16.
- configuration_address, 2100, config_addr value that selects this block.

Ports:
- a_clk  in  1  single clock for all logic.
- a_rst  in  1  synchronous, active-high reset.
- config_addr  in  32  config bus address.
- config_data  in  512  config bus data.
- S_AXIS_tdata  in  SAXIS_TDATA_WIDTH  signed input sample.
- S_AXIS_tvalid  in  1  input sample valid. There is no tready; input is never stalled.
- M_AXIS_tdata  out  MAXIS_TDATA_WIDTH  result.
- M_AXIS_tvalid  out  1  result valid.
- M_AXIS_tready  in  1  downstream accept.
- block_count  out  32  completed blocks; wraps modulo 2^32.
- overrun_count  out  16  results lost; saturates at 16'hFFFF.
- busy  out  1  high while enabled and the current block is partially filled (count != 0).

Behaviour:
- Reset and clocking: all state changes on posedge a_clk. a_rst dominates everything else in the same cycle.
- Reset values:
  - M_AXIS_tdata = 0, M_AXIS_tvalid = 0, block_count = 0, overrun_count = 0, busy = 0.
  - Accumulator = 0, sample count = 0.
  - Config: enable = 0, K = 0, mode = 0.
- Config latch: applies in any cycle where config_addr == configuration_address.
  - K <= config_data[4:0]; values above 16 are clamped to 16.
  - enable <= config_data[32].
  - mode <= config_data[33]; 0 = mean, 1 = sum.
  - clr_cnt = config_data[34]: when set, zero block_count and overrun_count this cycle.
- Any config-match cycle also aborts the current block: accumulator and count go to 0 and the sample presented that cycle is discarded.
  - The output register is untouched. A pending result stays valid until accepted.
- State machine:
  - IDLE (enable = 0): samples are ignored; accumulator and count are held at 0.
  - ACC (enable = 1): on each S_AXIS_tvalid, acc_next = acc + sign-extended sample and count increments.
  - When the incoming sample makes count == 2^K, the block completes:
    - result is computed from acc_next;
    - acc <= 0, count <= 0, block_count increments;
    - the state remains ACC.
  - Clearing enable mid-block discards the partial block and returns to IDLE.
- Result arithmetic:
  - Mean mode: acc_next >>> K (arithmetic shift, floor toward -inf), lower MAXIS_TDATA_WIDTH bits. The result is always in range.
  - Sum mode: acc_next saturated to the signed MAXIS_TDATA_WIDTH range, i.e. 0x7FFFFFFF / 0x80000000 at 32 bits.
  - K = 0: passthrough; every valid sample is a result.
- Latency: the completing sample accepted at edge t gives M_AXIS_tvalid = 1 and the result after edge t.
- Output handshake:
  - M_AXIS_tvalid stays high and M_AXIS_tdata stays stable until a cycle with M_AXIS_tready = 1; tvalid then clears on that edge.
  - If a new result completes while the register is valid and tready = 0: overwrite the data, keep tvalid = 1, increment overrun_count.
  - If a new result completes in the same cycle tready = 1: load the new result, keep tvalid = 1, no overrun.
- No internal overflow is possible: ACC_WIDTH covers 2^16 full-scale samples.

Test Plan:
- Reset, K=0 passthrough:
  - Apply reset, then program enable=1, K=0, mean mode; tready=1.
  - Drive samples 5, -7, 0x7FFFFFFF on consecutive cycles.
  - Required: M_AXIS_tdata equals each sample one cycle later, tvalid high for 3 cycles, block_count = 3.
- Mean with floor, K=2, gapped tvalid:
  - Send samples 1, 2, 3, -1 with idle cycles between them.
  - Required: result 1, since 5>>>2 = 1.
  - Repeat with samples -1, -1, -1, -2: required result -2 (floor of -1.25), block_count = 2, busy high between the samples of a block.
- Sum saturation, K=4, mode=sum:
  - Send 16 samples of 0x40000000: required result 0x7FFFFFFF.
  - Send 16 samples of 0xC0000000: required result 0x80000000.
- Backpressure and overrun, K=0, tready=0:
  - Send samples 10, 11, 12: required tdata = 12, tvalid = 1, overrun_count = 2.
  - Raise tready for one cycle: tvalid falls.
  - Write config with clr_cnt=1: block_count = 0, overrun_count = 0.
- Simultaneous complete and accept:
  - K=0, tvalid pending with value 7.
  - In the same cycle assert tready=1 and sample 8: required tdata = 8, tvalid = 1, overrun_count unchanged.
- Abort and reset mid-block, K=3:
  - Send 5 samples, then a config write: busy drops and the next 8 samples alone form the result.
  - Assert a_rst mid-block with tvalid pending: all outputs return to 0 next cycle.
  - After reset the block is disabled: samples produce no output until it is re-enabled by config.
